fd_pipe: RTL and testbench

Fetch-to-decode pipeline register: the receiving end of the fetch stage's PC/instruction interface. Each cycle it captures the instruction fetched at the current fetch PC and presents it to the decode stage together with its PC, PC+8 link value, delay-slot flag, valid bit and fetch exception code. It honours the decode-stage stall (which also drives the fetch stage's hold input), branch/jump flushes and exception/interrupt flushes. It keeps a saturating stall-cycle counter for performance debug.

---
 rtl/fd_pipe.sv | 109 ++++++++++
 tb/tb_fd_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fd_pipe.sv
// fd_pipe: fetch-to-decode pipeline register with stall/flush/exception-flush and a saturating stall counter.
// Latency 1 cycle; Stop_D holds every register (fetch is held by the same signal). Optional macro: FD_FETCH_EXC_EN.
// Backpressure: none generated here; Stop_D from decode freezes this stage in place.
module fd_pipe #(
   parameter logic [31:0] IM_BASE = 32'h0000_3000,
   parameter logic [31:0] IM_END  = 32'h0000_6FFF,
   parameter logic [31:0] EXC_PC  = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_F_In,
   input  logic [31:0] Instr_F_In,
   input  logic        BD_F_In,
   input  logic        Stop_D,
   input  logic        Flush_D,
   input  logic        Req,
   output logic [31:0] PC_D_Out,
   output logic [31:0] PCPlus8_D_Out,
   output logic [31:0] Instr_D_Out,
   output logic        BD_D_Out,
   output logic        Valid_D_Out,
   output logic [4:0]  ExcCode_D_Out,
   output logic [31:0] StallCnt_Out
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic [31:0] instr_d;
   logic        bd_d;
   logic        valid_d;
   logic [4:0]  exc_d;
   logic [31:0] stall_cnt;

   logic [31:0] load_instr;
   logic [4:0]  load_exc;
   logic [31:0] fetch_pc8;

   assign fetch_pc8 = PC_F_In + 32'd8;

`ifdef FD_FETCH_EXC_EN
   logic fetch_bad;

   // A faulting fetch still enters decode as valid so the exception reaches EPC with its PC.
   always_comb begin
      fetch_bad  = (PC_F_In[1:0] != 2'b00) || (PC_F_In < IM_BASE) || (PC_F_In > IM_END);
      load_instr = Instr_F_In;
      load_exc   = EXC_NONE;
      if (fetch_bad) begin
         load_instr = 32'd0;
         load_exc   = EXC_ADEL;
      end
   end
`else
   always_comb begin
      load_instr = Instr_F_In;
      load_exc   = EXC_NONE;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_d      <= IM_BASE;
         pc8_d     <= IM_BASE + 32'd8;
         instr_d   <= 32'd0;
         bd_d      <= 1'b0;
         valid_d   <= 1'b0;
         exc_d     <= EXC_NONE;
         stall_cnt <= 32'd0;
      end else if (Req) begin
         pc_d      <= EXC_PC;
         pc8_d     <= EXC_PC + 32'd8;
         instr_d   <= 32'd0;
         bd_d      <= 1'b0;
         valid_d   <= 1'b0;
         exc_d     <= EXC_NONE;
      end else if (Stop_D) begin
         // Hold the pipeline contents; only the counter moves, saturating at all-ones.
         if (stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end else if (Flush_D) begin
         pc_d      <= PC_F_In;
         pc8_d     <= fetch_pc8;
         instr_d   <= 32'd0;
         bd_d      <= 1'b0;
         valid_d   <= 1'b0;
         exc_d     <= EXC_NONE;
      end else begin
         pc_d      <= PC_F_In;
         pc8_d     <= fetch_pc8;
         instr_d   <= load_instr;
         bd_d      <= BD_F_In;
         valid_d   <= 1'b1;
         exc_d     <= load_exc;
      end
   end

   assign PC_D_Out      = pc_d;
   assign PCPlus8_D_Out = pc8_d;
   assign Instr_D_Out   = instr_d;
   assign BD_D_Out      = bd_d;
   assign Valid_D_Out   = valid_d;
   assign ExcCode_D_Out = exc_d;
   assign StallCnt_Out  = stall_cnt;

endmodule

// File: tb/tb_fd_pipe.sv
// Bench for fd_pipe: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_fd_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC_F_In, Instr_F_In;
   logic        BD_F_In, Stop_D, Flush_D, Req;
   logic [31:0] PC_D_Out, PCPlus8_D_Out, Instr_D_Out, StallCnt_Out;
   logic        BD_D_Out, Valid_D_Out;
   logic [4:0]  ExcCode_D_Out;

   int total = 0;
   int bad   = 0;

   // behavioural expectation of the decode-stage contents
   logic [31:0] m_pc, m_instr, m_cnt;
   logic        m_bd, m_valid;
   logic [4:0]  m_exc;

   always #5 clk = ~clk;

   fd_pipe dut (
      .clk(clk), .reset(reset), .PC_F_In(PC_F_In), .Instr_F_In(Instr_F_In),
      .BD_F_In(BD_F_In), .Stop_D(Stop_D), .Flush_D(Flush_D), .Req(Req),
      .PC_D_Out(PC_D_Out), .PCPlus8_D_Out(PCPlus8_D_Out), .Instr_D_Out(Instr_D_Out),
      .BD_D_Out(BD_D_Out), .Valid_D_Out(Valid_D_Out), .ExcCode_D_Out(ExcCode_D_Out),
      .StallCnt_Out(StallCnt_Out)
   );

   function automatic bit addr_faults(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFF);
   endfunction

   // Advance the model by the spec's per-edge priority, then clock the DUT and settle.
   task automatic step();
      if (reset) begin
         m_pc = 32'h3000; m_instr = 0; m_bd = 0; m_valid = 0; m_exc = 0; m_cnt = 0;
      end else if (Req) begin
         m_pc = 32'h4180; m_instr = 0; m_bd = 0; m_valid = 0; m_exc = 0;
      end else if (Stop_D) begin
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (Flush_D) begin
         m_pc = PC_F_In; m_instr = 0; m_bd = 0; m_valid = 0; m_exc = 0;
      end else begin
         m_pc = PC_F_In; m_instr = Instr_F_In; m_bd = BD_F_In; m_valid = 1; m_exc = 0;
`ifdef FD_FETCH_EXC_EN
         if (addr_faults(PC_F_In)) begin
            m_instr = 0; m_exc = 5'd4;
         end
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic bd,
                        input logic stop, input logic flush, input logic rq, input logic rst);
      PC_F_In = pc; Instr_F_In = ins; BD_F_In = bd;
      Stop_D = stop; Flush_D = flush; Req = rq; reset = rst;
   endtask

   task automatic test_reset();
      drive(32'h1234, 32'hFFFF_FFFF, 1, 0, 0, 0, 1);
      step();
      total++; if (PC_D_Out !== 32'h3000) begin bad++; $display("FAIL reset_pc: got %h want %h", PC_D_Out, 32'h3000); end
      total++; if (PCPlus8_D_Out !== 32'h3008) begin bad++; $display("FAIL reset_pc8: got %h want %h", PCPlus8_D_Out, 32'h3008); end
      total++; if ({Instr_D_Out, BD_D_Out, Valid_D_Out, ExcCode_D_Out} !== 39'd0) begin
         bad++; $display("FAIL reset_fields: instr %h bd %b valid %b exc %0d want all zero", Instr_D_Out, BD_D_Out, Valid_D_Out, ExcCode_D_Out); end
      total++; if (StallCnt_Out !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", StallCnt_Out); end
   endtask

   task automatic test_normal();
      drive(32'h3000, 32'h3C01_0001, 0, 0, 0, 0, 0);
      step();
      total++; if (PC_D_Out !== 32'h3000 || PCPlus8_D_Out !== 32'h3008) begin
         bad++; $display("FAIL normal_pc: got %h/%h want 3000/3008", PC_D_Out, PCPlus8_D_Out); end
      total++; if (Instr_D_Out !== 32'h3C01_0001 || Valid_D_Out !== 1'b1) begin
         bad++; $display("FAIL normal_instr: got %h v%b want 3c010001 v1", Instr_D_Out, Valid_D_Out); end
      drive(32'h3004, 32'h3421_0002, 1, 0, 0, 0, 0);
      step();
      total++; if (PC_D_Out !== 32'h3004 || BD_D_Out !== 1'b1) begin
         bad++; $display("FAIL normal_next: got %h bd%b want 3004 bd1", PC_D_Out, BD_D_Out); end
   endtask

   task automatic test_stall();
      drive(32'h3008, 32'h0000_0020, 0, 1, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         step();
         total++; if (PC_D_Out !== 32'h3004 || Instr_D_Out !== 32'h3421_0002 || StallCnt_Out !== k) begin
            bad++; $display("FAIL stall_hold%0d: got pc %h instr %h cnt %0d want 3004 34210002 %0d", k, PC_D_Out, Instr_D_Out, StallCnt_Out, k); end
      end
      Stop_D = 0;
      step();
      total++; if (PC_D_Out !== 32'h3008 || StallCnt_Out !== 32'd3) begin
         bad++; $display("FAIL stall_release: got %h cnt %0d want 3008 cnt 3", PC_D_Out, StallCnt_Out); end
   endtask

   task automatic test_flush();
      drive(32'h300C, 32'hDEAD_BEEF, 1, 0, 1, 0, 0);
      step();
      total++; if (PC_D_Out !== 32'h300C || Instr_D_Out !== 0 || Valid_D_Out !== 0 || BD_D_Out !== 0) begin
         bad++; $display("FAIL flush_bubble: got pc %h instr %h v%b bd%b want 300c 0 0 0", PC_D_Out, Instr_D_Out, Valid_D_Out, BD_D_Out); end
      drive(32'h3010, 32'h1111_2222, 0, 0, 0, 0, 0);
      step();
      drive(32'h3014, 32'h3333_4444, 0, 1, 1, 0, 0);
      step();
      total++; if (PC_D_Out !== 32'h3010 || Instr_D_Out !== 32'h1111_2222 || Valid_D_Out !== 1'b1 || StallCnt_Out !== 32'd4) begin
         bad++; $display("FAIL flush_stall_hold: got pc %h instr %h v%b cnt %0d want 3010 11112222 1 4", PC_D_Out, Instr_D_Out, Valid_D_Out, StallCnt_Out); end
   endtask

   task automatic test_req();
      drive(32'h3018, 32'h5555_6666, 1, 1, 0, 1, 0);
      step();
      total++; if (PC_D_Out !== 32'h4180 || PCPlus8_D_Out !== 32'h4188 || Valid_D_Out !== 0) begin
         bad++; $display("FAIL req_over_stall: got %h/%h v%b want 4180/4188 v0", PC_D_Out, PCPlus8_D_Out, Valid_D_Out); end
      total++; if (StallCnt_Out !== 32'd4) begin bad++; $display("FAIL req_cnt: got %0d want 4", StallCnt_Out); end
      drive(32'h4180, 32'h7777_8888, 0, 1, 0, 0, 0);
      step();
      step();
      reset = 1;
      step();
      total++; if (PC_D_Out !== 32'h3000 || Valid_D_Out !== 0 || StallCnt_Out !== 0 || Instr_D_Out !== 0) begin
         bad++; $display("FAIL reset_mid_stall: got pc %h v%b cnt %0d instr %h want 3000 0 0 0", PC_D_Out, Valid_D_Out, StallCnt_Out, Instr_D_Out); end
      reset = 0; Stop_D = 0;
   endtask

   task automatic test_fetch_exc();
      drive(32'h3002, 32'hABCD_0123, 0, 0, 0, 0, 0);
      step();
`ifdef FD_FETCH_EXC_EN
      total++; if (ExcCode_D_Out !== 5'd4 || Instr_D_Out !== 0 || PC_D_Out !== 32'h3002 || Valid_D_Out !== 1) begin
         bad++; $display("FAIL exc_misaligned: got exc %0d instr %h pc %h v%b want 4 0 3002 1", ExcCode_D_Out, Instr_D_Out, PC_D_Out, Valid_D_Out); end
      PC_F_In = 32'h7000; step();
      total++; if (ExcCode_D_Out !== 5'd4) begin bad++; $display("FAIL exc_above: got %0d want 4", ExcCode_D_Out); end
      PC_F_In = 32'h2FFC; step();
      total++; if (ExcCode_D_Out !== 5'd4) begin bad++; $display("FAIL exc_below: got %0d want 4", ExcCode_D_Out); end
      PC_F_In = 32'h6FFC; step();
      total++; if (ExcCode_D_Out !== 5'd0 || Instr_D_Out !== 32'hABCD_0123) begin
         bad++; $display("FAIL exc_last_word: got exc %0d instr %h want 0 abcd0123", ExcCode_D_Out, Instr_D_Out); end
`else
      total++; if (ExcCode_D_Out !== 5'd0 || Instr_D_Out !== 32'hABCD_0123 || PC_D_Out !== 32'h3002) begin
         bad++; $display("FAIL exc_disabled: got exc %0d instr %h pc %h want 0 abcd0123 3002", ExcCode_D_Out, Instr_D_Out, PC_D_Out); end
      PC_F_In = 32'h7000; step();
      total++; if (ExcCode_D_Out !== 5'd0 || PC_D_Out !== 32'h7000) begin
         bad++; $display("FAIL exc_disabled_range: got exc %0d pc %h want 0 7000", ExcCode_D_Out, PC_D_Out); end
`endif
   endtask

   task automatic test_random();
      logic [31:0] pc;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0: pc = 32'h3000 + ($urandom_range(0, 16383) & 32'hFFFF_FFFC);
            1: pc = 32'h2FF0 + $urandom_range(0, 31);
            2: pc = 32'h6FF0 + $urandom_range(0, 31);
            default: pc = $urandom;
         endcase
         drive(pc, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 39) == 0));
         step();
         total++;
         if (PC_D_Out !== m_pc || PCPlus8_D_Out !== m_pc + 32'd8 || Instr_D_Out !== m_instr || BD_D_Out !== m_bd ||
             Valid_D_Out !== m_valid || ExcCode_D_Out !== m_exc || StallCnt_Out !== m_cnt) begin
            bad++;
            $display("FAIL random%0d: got pc %h pc8 %h in %h bd%b v%b exc %0d cnt %0d want pc %h pc8 %h in %h bd%b v%b exc %0d cnt %0d",
                     n, PC_D_Out, PCPlus8_D_Out, Instr_D_Out, BD_D_Out, Valid_D_Out, ExcCode_D_Out, StallCnt_Out,
                     m_pc, m_pc + 32'd8, m_instr, m_bd, m_valid, m_exc, m_cnt);
         end
      end
   endtask

   task automatic test_saturation();
      drive(32'h3000, 32'h0, 0, 0, 0, 0, 0);
      step();
      force dut.stall_cnt = 32'hFFFF_FFFE;
      release dut.stall_cnt;
      m_cnt = 32'hFFFF_FFFE;
      Stop_D = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (StallCnt_Out !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL sat_cnt%0d: got %h want ffffffff", k, StallCnt_Out); end
      end
      Stop_D = 0;
   endtask

   initial begin
      drive(32'h0, 32'h0, 0, 0, 0, 0, 1);
      test_reset();
      test_normal();
      test_stall();
      test_flush();
      test_req();
      test_fetch_exc();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
